iomem_dma: RTL and testbench

- Bus initiator for the PicoSoC iomem valid/ready peripheral bus. It is the master-side counterpart of the GPIO and template responders.
- Copies a block of 32-bit words from a source address to a destination address using alternating read and write transactions.
- Sits in the board top level beside the responders. Software or a control FSM starts it through a simple start/busy/done interface.

---
 rtl/iomem_dma.sv | 140 ++++++++++++++
 tb/tb_iomem_dma.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iomem_dma.sv
// iomem_dma: word-copy bus initiator for the PicoSoC iomem valid/ready bus.
// Optional per-transaction m_ready timeout is built when IOMEM_DMA_TIMEOUT_EN is defined.
module iomem_dma #(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [3:0]           m_wstrb,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  output logic [2:0]           dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RD_GAP = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_WR_GAP = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [29:0]          src_q, src_d;
  logic [29:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          data_q, data_d;
  logic                 err_q, err_d;
  logic                 unused_bits;

`ifdef IOMEM_DMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expired;

  // Counts waiting cycles of the current request; zero whenever no request is pending.
  assign to_cnt_d   = (m_valid && !m_ready) ? to_cnt_q + TO_W'(1) : '0;
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  assign unused_bits = ^{cfg_src[1:0], cfg_dst[1:0]};
`else
  assign unused_bits = ^{cfg_src[1:0], cfg_dst[1:0], TIMEOUT_CYCLES != 0};
`endif

  // Bus handshake: a request (m_valid plus address/strobe/data) is held unchanged
  // until m_ready is sampled high at a clk edge; that edge completes it. Every
  // request is followed by one idle cycle, so a held-high m_ready acks only once.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          src_d   = cfg_src[31:2];
          dst_d   = cfg_dst[31:2];
          len_d   = cfg_len;
          err_d   = 1'b0;
          state_d = (cfg_len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        if (m_ready) begin
          data_d  = m_rdata;
          state_d = S_RD_GAP;
        end
`ifdef IOMEM_DMA_TIMEOUT_EN
        else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
`endif
      end
      S_RD_GAP: state_d = S_WR;
      S_WR: begin
        if (m_ready) begin
          src_d   = src_q + 30'd1;
          dst_d   = dst_q + 30'd1;
          len_d   = len_q - LEN_WIDTH'(1);
          state_d = S_WR_GAP;
        end
`ifdef IOMEM_DMA_TIMEOUT_EN
        else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
`endif
      end
      S_WR_GAP: state_d = (len_q == '0) ? S_FIN : S_RD;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign m_valid     = (state_q == S_RD) || (state_q == S_WR);
  assign m_wstrb     = (state_q == S_WR) ? 4'hF : 4'h0;
  assign m_addr      = (state_q == S_RD) ? {src_q, 2'b00} :
                       (state_q == S_WR) ? {dst_q, 2'b00} : 32'h0;
  assign m_wdata     = (state_q == S_WR) ? data_q : 32'h0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iomem_dma.sv
// Self-checking bench for iomem_dma: table of copy jobs plus reset/restart/timeout sequences.
// The timeout sequence is compiled in only when IOMEM_DMA_TIMEOUT_EN is defined.
module tb_iomem_dma;

  localparam logic [31:0] PAT   = 32'h05A5A5A5;  // responder read data = address ^ PAT
  localparam int          TXN_W = 68;            // {wstrb, addr, wdata}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, err, m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [TXN_W-1:0] exp_q[$];

  // delay < 0 means m_ready is held high for the whole job
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          delay;
    logic        restart;
    logic        fin_start;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  iomem_dma #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len), .busy(busy), .done(done), .err(err),
    .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [TXN_W-1:0] got, input logic [TXN_W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int               wait_cnt, done_edge, per_word;
    logic [TXN_W-1:0] first, cur;
    logic [31:0]      a_src, a_dst;
    logic             hold;
    hold     = (v.delay < 0);
    per_word = hold ? 4 : 2 * v.delay + 4;
    a_src    = v.src & ~32'h3;
    a_dst    = v.dst & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      exp_q.push_back({4'h0, a_src + 32'(4 * i), 32'h0});
      exp_q.push_back({4'hF, a_dst + 32'(4 * i), (a_src + 32'(4 * i)) ^ PAT});
    end
    m_ready   = hold;
    wait_cnt  = 0;
    done_edge = -1;
    first     = '0;
    cfg_src   = v.src;
    cfg_dst   = v.dst;
    cfg_len   = v.len;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      cur = {m_wstrb, m_addr, m_wdata};
      if (v.restart && cyc == 3) begin
        cfg_src   = 32'h0BAD_0000;
        cfg_dst   = 32'h0BAD_1000;
        cfg_len   = 16'd7;
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      if (done) begin
        done_edge = cyc - 1;
        check($sformatf("v%0d_busy_at_done", id), TXN_W'(busy), TXN_W'(0));
        if (v.fin_start) begin
          cfg_start = 1'b1;
          cfg_len   = 16'd5;
        end
        break;
      end
      check($sformatf("v%0d_busy", id), TXN_W'(busy), TXN_W'(v.len != 0));
      if (!hold && m_ready) begin
        check($sformatf("v%0d_gap", id), TXN_W'(m_valid), TXN_W'(0));
        m_ready = 1'b0;
      end else if (m_valid) begin
        wait_cnt++;
        if (wait_cnt == 1) first = cur;
        else check($sformatf("v%0d_stable", id), cur, first);
        if (hold || wait_cnt > v.delay) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d_extra_txn: got %h, expected no request", id, cur);
          end else begin
            check($sformatf("v%0d_txn", id), cur, exp_q.pop_front());
          end
          m_rdata  = m_addr ^ PAT;
          m_ready  = 1'b1;
          wait_cnt = 0;
        end
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_done_edge", id), TXN_W'(done_edge), TXN_W'(int'(v.len) * per_word));
    m_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_post_done", id), TXN_W'({done, busy, err, m_valid}), TXN_W'(0));
    cfg_start = 1'b0;
    check($sformatf("v%0d_txn_left", id), TXN_W'(exp_q.size()), TXN_W'(0));
    @(negedge clk);
  endtask

  initial begin
    logic found;
    vecs[0] = '{32'h0300_0000, 32'h0400_0010, 16'd3,  1, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd0,  1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0100, 32'h0000_0200, 16'd2,  5, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFE, 32'h0000_0013, 16'd2,  1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0040, 32'h0000_0080, 16'd4, -1, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0500, 32'h0000_0600, 16'd2,  1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0001, 32'h0000_0007, 16'd1,  0, 1'b0, 1'b0};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", TXN_W'({busy, done, err, m_valid, m_wstrb, dbg_state}), TXN_W'(0));
    check("reset_bus", {4'h0, m_addr, m_wdata}, TXN_W'(0));
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while a write request is pending
    cfg_src   = 32'h0000_2000;
    cfg_dst   = 32'h0000_3000;
    cfg_len   = 16'd3;
    cfg_start = 1'b1;
    m_ready   = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    found     = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (m_valid && m_wstrb == 4'hF) begin
        found = 1'b1;
      end else begin
        if (m_ready) m_ready = 1'b0;
        else if (m_valid) begin
          m_rdata = m_addr ^ PAT;
          m_ready = 1'b1;
        end
        @(negedge clk);
      end
    end
    check("reached_wr", TXN_W'(found), TXN_W'(1));
    resetn = 1'b0;
    @(negedge clk);
    check("reset_mid_wr", TXN_W'({m_valid, busy, done}), TXN_W'(0));
    @(negedge clk);
    check("reset_held", TXN_W'({m_valid, busy, done, dbg_state}), TXN_W'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("after_reset_idle", TXN_W'({m_valid, busy, done}), TXN_W'(0));
    run_vec(9, vecs[0]);

`ifdef IOMEM_DMA_TIMEOUT_EN
    begin
      int   n_valid;
      logic done_seen;
      n_valid   = 0;
      done_seen = 1'b0;
      m_ready   = 1'b0;
      cfg_src   = 32'h0000_0100;
      cfg_dst   = 32'h0000_0200;
      cfg_len   = 16'd2;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      for (int c = 0; c < 40 && !done_seen; c++) begin
        if (done) begin
          done_seen = 1'b1;
          check("to_err_at_done", TXN_W'({err, m_valid, busy}), TXN_W'(3'b100));
        end else begin
          if (m_valid) n_valid++;
          @(negedge clk);
        end
      end
      check("to_done_seen", TXN_W'(done_seen), TXN_W'(1));
      check("to_valid_cycles", TXN_W'(n_valid), TXN_W'(8));
      @(negedge clk);
      check("to_err_sticky", TXN_W'({err, done, busy}), TXN_W'(3'b100));
      cfg_len   = 16'd0;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("to_err_cleared", TXN_W'({err, done}), TXN_W'(2'b01));
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
